note_voice_controller: RTL and testbench
========================================

// Module: note_voice_controller
// PURPOSE
//  Sits directly downstream of the pattern sequencer and paces it.
//  - Requests one note at a time on o_note_stb and latches the note when i_note_valid returns.
//  - Holds the note for its length, measured in tempo ticks, and drives gate, pitch, instrument
//    and a 4-bit decaying volume to the oscillator/mixer stage.
//  - Requests the next note when the current one expires.
// PARAMETERS
//  TICKS_PER_UNIT  6   i_tick pulses per note-length unit (>=1)
//  REQ_TIMEOUT     15  clocks to wait for i_note_valid before re-issuing o_note_stb (>=6)
// PORTS
//  i_clk         in   1  clock
//  i_rst         in   1  reset, synchronous, active-high
//  i_enable      in   1  run enable; low forces IDLE
//  i_tick        in   1  tempo tick, 1-clock pulse
//  o_note_stb    out  1  next-note request, 1-clock pulse
//  i_note_valid  in   1  note fields valid this cycle (1-clock pulse)
//  i_note        in   6  pitch; 0 = rest
//  i_note_len    in   5  length in units; 0 = 32 units
//  i_instrument  in   4  instrument; [2:0] = decay period in ticks (0 = no decay)
//  o_pitch       out  6  latched pitch
//  o_instrument  out  4  latched instrument
//  o_gate        out  1  voice active (PLAY and pitch != 0)
//  o_volume      out  4  envelope volume
//  o_note_start  out  1  1-clock pulse on first PLAY cycle of each note
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; all counters 0.
//  - Registered FSM: IDLE -> REQUEST -> WAIT_NOTE -> PLAY -> REQUEST ...
//  - IDLE: o_gate=0, o_volume=0. i_enable=1 -> REQUEST.
//  - REQUEST: o_note_stb=1 for exactly this cycle; clear timeout counter; -> WAIT_NOTE.
//  - WAIT_NOTE:
//    - i_note_valid=1 -> latch pitch/instrument into o_pitch/o_instrument;
//      units = (len==0) ? 32 : len; subtick = TICKS_PER_UNIT-1; -> PLAY.
//    - Else the timeout counter increments. Reaching REQ_TIMEOUT -> REQUEST (retry; a dropped
//      strobe is recovered here).
//  - Upstream latency: stb at cycle N gives valid at N+5; note_start at N+6.
//  - PLAY:
//    - First cycle: o_note_start=1; o_volume=15 if pitch!=0, else 0; decay counter = 0.
//    - On each i_tick: subtick==0 -> reload TICKS_PER_UNIT-1 and decrement units; else decrement
//      subtick. The tick that takes units 1->0 moves the FSM to REQUEST next cycle.
//    - Note duration is therefore exactly units*TICKS_PER_UNIT ticks.
//    - Decay: if instrument[2:0]!=0, each i_tick increments the decay counter. When the counter
//      reaches instrument[2:0], clear it and decrement o_volume, saturating at 0.
//  - o_gate = (state==PLAY) && (o_pitch!=0). A rest is still timed normally.
//  - i_tick outside PLAY is ignored, including a tick coincident with i_note_valid.
//  - i_note_valid outside WAIT_NOTE is ignored (a late reply after a timeout or disable).
//  - i_enable=0 in any state -> IDLE next cycle: o_gate=0, o_volume=0, no stb.
//    o_pitch/o_instrument hold their values.
//  - Unit counter 6 bits (max 32); subtick width $clog2(TICKS_PER_UNIT+1); volume never wraps.
//  - Reset mid-note returns to IDLE immediately with all outputs 0.
// TESTING
//  - Reset, enable; upstream model (5-cycle latency) returns pitch 10, len 2, instr 0
//    -> one stb pulse; note_start 6 clks later; gate=1, vol=15 for 12 ticks; next stb the
//    cycle after the 12th tick.
//  - Len 0, pitch 5 -> gate held for 192 ticks, then stb.
//  - Pitch 0, len 1 -> gate=0, vol=0 for 6 ticks, note_start still pulses, then stb.
//  - Instr 4'b0010, pitch 3, len 31 -> vol 15 at start; 14 after 2 ticks; 0 after 30 ticks;
//    stays 0.
//  - Upstream ignores first stb -> stb re-issued 15 clks into WAIT_NOTE; second reply
//    accepted normally.
//  - Deassert i_enable mid-PLAY -> gate=0, vol=0 next cycle. A valid pulse arriving in IDLE
//    leaves o_pitch unchanged. Re-enable gives a fresh stb.

Source files
------------

// File: rtl/note_voice_controller.sv
// note_voice_controller: paces the pattern sequencer one note at a time.
// It requests a note, latches the reply, and holds the note for its length
// in tempo ticks. While the note plays it drives gate, pitch, instrument and a
// decaying 4-bit volume. A request that gets no reply is retried after a
// bounded wait.
module note_voice_controller #(
  parameter int TICKS_PER_UNIT = 6,
  parameter int REQ_TIMEOUT    = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_tick,
  output logic       o_note_stb,
  input  logic       i_note_valid,
  input  logic [5:0] i_note,
  input  logic [4:0] i_note_len,
  input  logic [3:0] i_instrument,
  output logic [5:0] o_pitch,
  output logic [3:0] o_instrument,
  output logic       o_gate,
  output logic [3:0] o_volume,
  output logic       o_note_start
);

  localparam int SW = $clog2(TICKS_PER_UNIT + 1);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [SW-1:0] SUB_INIT = SW'(TICKS_PER_UNIT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_NOTE = 2'd2,
    PLAY      = 2'd3
  } state_e;

  state_e          state_q;
  logic [5:0]      units_q;
  logic [SW-1:0]   subtick_q;
  logic [TW-1:0]   tocnt_q;
  logic [2:0]      dcnt_q;
  logic [5:0]      pitch_q;
  logic [3:0]      instr_q;
  logic            gate_q;
  logic [3:0]      vol_q;
  logic            stb_q;
  logic            start_q;

  logic [3:0]      vol_dec_d;
  logic [2:0]      dcnt_inc_d;
  logic            note_end_d;

  // Saturating volume step, decay counter step and end-of-note detect.
  always_comb begin
    vol_dec_d  = (vol_q == 4'd0) ? 4'd0 : vol_q - 4'd1;
    dcnt_inc_d = dcnt_q + 3'd1;
    note_end_d = (subtick_q == '0) && (units_q == 6'd1);
  end

  // Control FSM; every output is registered and set on entry to its state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      units_q   <= '0;
      subtick_q <= '0;
      tocnt_q   <= '0;
      dcnt_q    <= '0;
      pitch_q   <= '0;
      instr_q   <= '0;
      gate_q    <= 1'b0;
      vol_q     <= '0;
      stb_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      stb_q   <= 1'b0;
      start_q <= 1'b0;
      if (!i_enable) begin
        // Pitch/instrument are left as they were; only the voice goes silent.
        state_q <= IDLE;
        gate_q  <= 1'b0;
        vol_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= REQUEST;
            stb_q   <= 1'b1;
            gate_q  <= 1'b0;
            vol_q   <= '0;
          end
          REQUEST: begin
            tocnt_q <= '0;
            state_q <= WAIT_NOTE;
          end
          WAIT_NOTE: begin
            if (i_note_valid) begin
              pitch_q   <= i_note;
              instr_q   <= i_instrument;
              units_q   <= (i_note_len == 5'd0) ? 6'd32 : {1'b0, i_note_len};
              subtick_q <= SUB_INIT;
              dcnt_q    <= '0;
              gate_q    <= (i_note != 6'd0);
              vol_q     <= (i_note != 6'd0) ? 4'd15 : 4'd0;
              start_q   <= 1'b1;
              state_q   <= PLAY;
            end else if (tocnt_q == TO_LAST) begin
              // No reply: the strobe was probably dropped, so ask again.
              state_q <= REQUEST;
              stb_q   <= 1'b1;
            end else begin
              tocnt_q <= tocnt_q + 1'b1;
            end
          end
          PLAY: begin
            if (i_tick) begin
              if (subtick_q == '0) begin
                subtick_q <= SUB_INIT;
                units_q   <= units_q - 6'd1;
              end else begin
                subtick_q <= subtick_q - 1'b1;
              end
              if (instr_q[2:0] != 3'd0) begin
                if (dcnt_inc_d == instr_q[2:0]) begin
                  dcnt_q <= '0;
                  vol_q  <= vol_dec_d;
                end else begin
                  dcnt_q <= dcnt_inc_d;
                end
              end
              if (note_end_d) begin
                state_q <= REQUEST;
                stb_q   <= 1'b1;
                gate_q  <= 1'b0;
                vol_q   <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_note_stb   = stb_q;
  assign o_note_start = start_q;
  assign o_pitch      = pitch_q;
  assign o_instrument = instr_q;
  assign o_gate       = gate_q;
  assign o_volume     = vol_q;

endmodule

// File: tb/tb_note_voice_controller.sv
// Directed bench for note_voice_controller: an upstream model with 5-cycle
// reply latency serves notes, and hand-computed timings are checked.
module tb_note_voice_controller;

  logic       clk = 1'b0;
  logic       rst, en, tick, valid;
  logic [5:0] note;
  logic [4:0] len;
  logic [3:0] instr;
  logic       stb, gate, start;
  logic [5:0] pitch;
  logic [3:0] ins_o, vol;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  note_voice_controller #(.TICKS_PER_UNIT(6), .REQ_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_tick(tick),
    .o_note_stb(stb), .i_note_valid(valid), .i_note(note),
    .i_note_len(len), .i_instrument(instr), .o_pitch(pitch),
    .o_instrument(ins_o), .o_gate(gate), .o_volume(vol),
    .o_note_start(start)
  );

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One tick per cycle; returns on the negedge after the tick was consumed.
  task automatic run_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // Upstream model: wait for stb (cycle N), reply during cycle N+5, and
  // return at the negedge of N+6 where note_start must be showing.
  task automatic serve(input logic [5:0] p, input logic [4:0] l,
                       input logic [3:0] ins, input bit tw);
    int n = 0;
    while (!stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stb_seen", stb, 1);
    @(negedge clk);
    check("stb_pulse", stb, 0);
    repeat (4) @(negedge clk);
    check("start_early", start, 0);
    note = p; len = l; instr = ins; valid = 1'b1; tick = tw;
    @(negedge clk);
    valid = 1'b0; tick = 1'b0;
    check("note_start", start, 1);
    check("pitch", pitch, p);
    check("instr", ins_o, ins);
    check("gate_start", gate, (p != 0) ? 1 : 0);
    check("vol_start", vol, (p != 0) ? 15 : 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; tick = 1'b0; valid = 1'b0;
    note = '0; len = '0; instr = '0;
    repeat (3) @(negedge clk);
    check("rst_stb", stb, 0);
    check("rst_gate", gate, 0);
    check("rst_vol", vol, 0);
    check("rst_pitch", pitch, 0);
    check("rst_start", start, 0);
    rst = 1'b0; en = 1'b1;

    // Pitch 10, len 2: 12 ticks of gate, stb right after the 12th.
    serve(6'd10, 5'd2, 4'd0, 1'b0);
    run_ticks(1);
    check("t1_start_pulse", start, 0);
    check("t1_vol", vol, 15);
    run_ticks(10);
    check("t1_gate11", gate, 1);
    check("t1_stb11", stb, 0);
    run_ticks(1);
    check("t1_stb12", stb, 1);
    check("t1_gate12", gate, 0);

    // Len 0 means 32 units = 192 ticks.
    serve(6'd5, 5'd0, 4'd0, 1'b0);
    run_ticks(191);
    check("t2_gate191", gate, 1);
    check("t2_stb191", stb, 0);
    run_ticks(1);
    check("t2_stb192", stb, 1);

    // Rest, len 1, with a tick coincident with valid that must be ignored.
    serve(6'd0, 5'd1, 4'd0, 1'b1);
    run_ticks(5);
    check("t3_stb5", stb, 0);
    check("t3_gate", gate, 0);
    run_ticks(1);
    check("t3_stb6", stb, 1);

    // Decay period 2: 14 after 2 ticks, 0 after 30, 186 ticks total.
    serve(6'd3, 5'd31, 4'b0010, 1'b0);
    run_ticks(1);
    check("t4_vol1", vol, 15);
    run_ticks(1);
    check("t4_vol2", vol, 14);
    run_ticks(27);
    check("t4_vol29", vol, 1);
    run_ticks(1);
    check("t4_vol30", vol, 0);
    run_ticks(10);
    check("t4_vol40", vol, 0);
    check("t4_gate40", gate, 1);
    run_ticks(145);
    check("t4_stb185", stb, 0);
    run_ticks(1);
    check("t4_stb186", stb, 1);

    // Ignore this stb: the retry comes 16 cycles after the first.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb && n < 40);
    check("retry_gap", n, 16);
    serve(6'd12, 5'd1, 4'd0, 1'b0);
    run_ticks(6);
    check("retry_done", stb, 1);

    // Disable mid-note, late valid in IDLE, then re-enable.
    serve(6'd20, 5'd4, 4'd0, 1'b0);
    run_ticks(3);
    en = 1'b0;
    @(negedge clk);
    check("dis_gate", gate, 0);
    check("dis_vol", vol, 0);
    check("dis_stb", stb, 0);
    note = 6'd33; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("idle_valid_pitch", pitch, 20);
    check("idle_stb", stb, 0);
    en = 1'b1;
    @(negedge clk);
    check("reen_stb", stb, 1);

    // Reset mid-note clears everything.
    serve(6'd7, 5'd3, 4'd5, 1'b0);
    run_ticks(1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_gate", gate, 0);
    check("mrst_vol", vol, 0);
    check("mrst_pitch", pitch, 0);
    check("mrst_instr", ins_o, 0);
    check("mrst_stb", stb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
